pop_sequencer: RTL and testbench

- Parametrised pulsed-optical-pumping (POP) timing generator. It produces repeating pump / microwave / probe / sample sequences from the 2.5 MHz system clock.
- Two sequence modes:
  - Ramsey: pump, pi/2, free precession, pi/2, probe.
  - Rabi: pump, single MW pulse, probe.
- Pi/2 and free-precession durations are adjustable at run time by button strobes, step-sized and saturating.
- Adjusted values take effect only at a sequence boundary. It sits between the button samplers and the laser/MW/ADC drive pins.

---
 rtl/pop_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pop_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_sequencer.sv
// Pulsed-optical-pumping sequencer: pump / MW / probe / sample gate generator with
// run-time pi/2 and free-precession adjustment. Define POP_SEQ_COUNT_EN to add seq_count.
module pop_sequencer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned PUMP_LEN      = 2000,
  parameter int unsigned DEAD_LEN      = 25,
  parameter int unsigned PIE_DEFAULT   = 10,
  parameter int unsigned FREE_DEFAULT  = 250,
  parameter int unsigned PROBE_LEN     = 500,
  parameter int unsigned SAMPLE_OFFSET = 50,
  parameter int unsigned SAMPLE_LEN    = 400,
  parameter int unsigned STEP          = 1,
  parameter int unsigned MIN_LEN       = 1,
  parameter int unsigned MAX_LEN       = 4000
) (
  input  logic             clock_2_5M,
  input  logic             load_defaults,
  input  logic             ramsey_mode,
  input  logic             pieovertwo_plus,
  input  logic             pieovertwo_minus,
  input  logic             freeprecess_plus,
  input  logic             freeprecess_minus,
  output logic             pump,
  output logic             probe,
  output logic             MW,
  output logic             sample,
  output logic             seq_start,
  output logic [WIDTH-1:0] pie_len,
  output logic [WIDTH-1:0] free_len
`ifdef POP_SEQ_COUNT_EN
  ,
  output logic [WIDTH-1:0] seq_count
`endif
);

  typedef logic [WIDTH-1:0] len_t;
  typedef logic [WIDTH:0]   ext_t;
  typedef enum logic [2:0] {StPump, StDead1, StMw1, StFree, StMw2, StDead2, StProbe} state_t;

  localparam int unsigned SampEndInt = (SAMPLE_OFFSET + SAMPLE_LEN < PROBE_LEN) ?
                                       SAMPLE_OFFSET + SAMPLE_LEN : PROBE_LEN;
  localparam len_t PumpLen   = len_t'(PUMP_LEN);
  localparam len_t DeadLen   = len_t'(DEAD_LEN);
  localparam len_t ProbeLen  = len_t'(PROBE_LEN);
  localparam len_t SampStart = len_t'(SAMPLE_OFFSET);
  localparam len_t SampEnd   = len_t'(SampEndInt);
  localparam len_t PieDef    = len_t'(PIE_DEFAULT);
  localparam len_t FreeDef   = len_t'(FREE_DEFAULT);
  localparam len_t One       = len_t'(1);
  localparam ext_t StepX     = ext_t'(STEP);
  localparam ext_t MinX      = ext_t'(MIN_LEN);
  localparam ext_t MaxX      = ext_t'(MAX_LEN);

  // One extra bit keeps the saturating add/subtract free of wrap-around.
  function automatic len_t adjust(len_t cur, logic up, logic dn);
    ext_t cur_x;
    ext_t res;
    cur_x = {1'b0, cur};
    res   = cur_x;
    if (up && !dn) begin
      res = cur_x + StepX;
      if (res > MaxX) res = MaxX;
    end else if (dn && !up) begin
      res = (cur_x < MinX + StepX) ? MinX : cur_x - StepX;
    end
    return res[WIDTH-1:0];
  endfunction

  state_t     state_q, state_d;
  len_t       cnt_q, cnt_d;
  len_t       phase_len;
  logic       phase_last;
  logic       seq_begin;
  len_t       pie_sh_q, pie_sh_d, free_sh_q, free_sh_d;
  len_t       pie_act_q, free_act_q;
  logic       ramsey_q;
  logic [3:0] btn, btn_q, btn_edge;
  logic       pump_q, probe_q, mw_q, sample_q, seq_start_q;

  assign btn       = {pieovertwo_plus, pieovertwo_minus, freeprecess_plus, freeprecess_minus};
  assign btn_edge  = btn & ~btn_q;
  assign pie_sh_d  = adjust(pie_sh_q, btn_edge[3], btn_edge[2]);
  assign free_sh_d = adjust(free_sh_q, btn_edge[1], btn_edge[0]);
  assign seq_begin = (state_q == StPump) && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    phase_len = PumpLen;
    unique case (state_q)
      StPump:           phase_len = PumpLen;
      StDead1, StDead2: phase_len = DeadLen;
      StMw1, StMw2:     phase_len = pie_act_q;
      StFree:           phase_len = free_act_q;
      StProbe:          phase_len = ProbeLen;
      default:          phase_len = PumpLen;
    endcase
    phase_last = (cnt_q == phase_len - One);
    cnt_d      = phase_last ? '0 : cnt_q + One;
    if (phase_last) begin
      unique case (state_q)
        StPump:  state_d = StDead1;
        StDead1: state_d = StMw1;
        StMw1:   state_d = ramsey_q ? StFree : StDead2;
        StFree:  state_d = StMw2;
        StMw2:   state_d = StDead2;
        StDead2: state_d = StProbe;
        default: state_d = StPump;
      endcase
    end
  end

  always_ff @(posedge clock_2_5M) begin
    if (load_defaults) begin
      state_q <= StPump;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gates are decoded from the current state, so they lag it by exactly one clock.
  always_ff @(posedge clock_2_5M) begin
    if (load_defaults) begin
      pie_sh_q    <= PieDef;
      free_sh_q   <= FreeDef;
      pie_act_q   <= PieDef;
      free_act_q  <= FreeDef;
      ramsey_q    <= 1'b1;
      btn_q       <= '0;
      pump_q      <= 1'b0;
      probe_q     <= 1'b0;
      mw_q        <= 1'b0;
      sample_q    <= 1'b0;
      seq_start_q <= 1'b0;
    end else begin
      pie_sh_q    <= pie_sh_d;
      free_sh_q   <= free_sh_d;
      btn_q       <= btn;
      if (seq_begin) begin
        pie_act_q  <= pie_sh_q;
        free_act_q <= free_sh_q;
        ramsey_q   <= ramsey_mode;
      end
      pump_q      <= (state_q == StPump);
      probe_q     <= (state_q == StProbe);
      mw_q        <= (state_q == StMw1) || (state_q == StMw2);
      sample_q    <= (state_q == StProbe) && (cnt_q >= SampStart) && (cnt_q < SampEnd);
      seq_start_q <= seq_begin;
    end
  end

`ifdef POP_SEQ_COUNT_EN
  len_t seq_cnt_q;

  always_ff @(posedge clock_2_5M) begin
    if (load_defaults) begin
      seq_cnt_q <= '0;
    end else if ((state_q == StProbe) && phase_last) begin
      seq_cnt_q <= seq_cnt_q + One;
    end
  end

  assign seq_count = seq_cnt_q;
`endif

  assign pump      = pump_q;
  assign probe     = probe_q;
  assign MW        = mw_q;
  assign sample    = sample_q;
  assign seq_start = seq_start_q;
  assign pie_len   = pie_sh_q;
  assign free_len  = free_sh_q;

endmodule

// File: tb/tb_pop_sequencer.sv
// Self-checking bench for pop_sequencer: directed sequence measurements, a button
// vector table, and randomized stimulus against a position-based reference model.
module tb_pop_sequencer;

  localparam int PUMP = 2000, DEAD = 25, PIE_D = 10, FREE_D = 250, PROBE = 500;
  localparam int SOFF = 50, SLEN = 400, STEP = 1, MINL = 1, MAXL = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic load_defaults = 1'b1, ramsey_mode = 1'b1;
  logic pp = 1'b0, pm = 1'b0, fp = 1'b0, fm = 1'b0;
  logic pump, probe, mw, sample, seq_start;
  logic [15:0] pie_len, free_len;
  logic pump2, probe2, mw2, sample2, seq_start2;
  logic [15:0] pie_len2, free_len2;
`ifdef POP_SEQ_COUNT_EN
  logic [15:0] seq_count, seq_count2;
`endif

  pop_sequencer dut (
    .clock_2_5M(clk), .load_defaults(load_defaults), .ramsey_mode(ramsey_mode),
    .pieovertwo_plus(pp), .pieovertwo_minus(pm), .freeprecess_plus(fp),
    .freeprecess_minus(fm), .pump(pump), .probe(probe), .MW(mw), .sample(sample),
    .seq_start(seq_start), .pie_len(pie_len), .free_len(free_len)
`ifdef POP_SEQ_COUNT_EN
    , .seq_count(seq_count)
`endif
  );

  pop_sequencer #(.FREE_DEFAULT(3999)) dut_hi (
    .clock_2_5M(clk), .load_defaults(load_defaults), .ramsey_mode(ramsey_mode),
    .pieovertwo_plus(pp), .pieovertwo_minus(pm), .freeprecess_plus(fp),
    .freeprecess_minus(fm), .pump(pump2), .probe(probe2), .MW(mw2), .sample(sample2),
    .seq_start(seq_start2), .pie_len(pie_len2), .free_len(free_len2)
`ifdef POP_SEQ_COUNT_EN
    , .seq_count(seq_count2)
`endif
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position within the sequence ----------------
  function automatic int period_of(int pie, int fr, bit ram);
    return PUMP + 2 * DEAD + pie + PROBE + (ram ? (fr + pie) : 0);
  endfunction

  // Returns {pump, probe, mw, sample, seq_start} for position p of a sequence.
  function automatic logic [4:0] gates_at(int p, int pie, int fr, bit ram);
    int len[7];
    int acc, ph, off, send;
    bit found;
    len   = '{PUMP, DEAD, pie, ram ? fr : 0, ram ? pie : 0, DEAD, PROBE};
    acc   = 0;
    ph    = 6;
    off   = 0;
    found = 0;
    for (int i = 0; i < 7; i++) begin
      if (!found && p < acc + len[i]) begin
        ph    = i;
        off   = p - acc;
        found = 1;
      end
      acc += len[i];
    end
    send = (SOFF + SLEN < PROBE) ? SOFF + SLEN : PROBE;
    return {ph == 0, ph == 6, (ph == 2) || (ph == 4), (ph == 6) && off >= SOFF && off < send,
            p == 0};
  endfunction

  function automatic int adj(int l, bit up, bit dn);
    if (up && !dn) return (l + STEP > MAXL) ? MAXL : l + STEP;
    if (dn && !up) return (l - STEP < MINL) ? MINL : l - STEP;
    return l;
  endfunction

  bit   model_ok = 0;
  int   pos, a_pie, a_free, sh_pie, sh_free, m_cnt;
  bit   a_ram;
  bit   prev[4];
  logic [4:0] exp_g;

  always @(posedge clk) begin
    if (load_defaults) begin
      model_ok = 1;
      sh_pie   = PIE_D;
      sh_free  = FREE_D;
      prev     = '{0, 0, 0, 0};
      pos      = 0;
      m_cnt    = 0;
      exp_g    = '0;
    end else if (model_ok) begin
      if (pos == 0) begin
        a_pie  = sh_pie;
        a_free = sh_free;
        a_ram  = ramsey_mode;
      end
      exp_g = gates_at(pos, a_pie, a_free, a_ram);
      if (pos == period_of(a_pie, a_free, a_ram) - 1) begin
        pos   = 0;
        m_cnt = (m_cnt + 1) % 65536;
      end else begin
        pos++;
      end
      sh_pie  = adj(sh_pie, pp && !prev[0], pm && !prev[1]);
      sh_free = adj(sh_free, fp && !prev[2], fm && !prev[3]);
      prev    = '{pp, pm, fp, fm};
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_gates", {pump, probe, mw, sample, seq_start}, exp_g);
      check("model_pie_len", pie_len, sh_pie);
      check("model_free_len", free_len, sh_free);
`ifdef POP_SEQ_COUNT_EN
      check("model_seq_count", seq_count, m_cnt);
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int plan, input int t);
    if (plan == 1) begin
      pm = (t >= 2040 && t < 2048 && t % 2 == 0);
      fp = (t >= 2048 && t < 2052 && t % 2 == 0);
    end else if (plan == 2 && t == 2030) begin
      ramsey_mode = 1'b0;
    end
  endtask

  // Starts on the cycle seq_start is seen high; returns on the next one.
  task automatic expect_seq(input string tag, input int plan, input int e_mwcnt,
                            input int e_mw1, input int e_gap, input int e_mw2,
                            input int e_period);
    int  t = 0, mw_end = 0, pstart = -1;
    int  r_pump = 0, r_mwcnt = 0, r_mw1 = 0, r_gap = 0, r_mw2 = 0;
    int  r_probe = 0, r_soff = -1, r_slen = 0;
    bit  mw_prev = 0, done = 0, ended = 0;
    while (!done) begin
      if (pump) r_pump++;
      if (mw && !mw_prev) begin
        r_mwcnt++;
        if (r_mwcnt == 2) r_gap = t - mw_end;
      end
      if (!mw && mw_prev) mw_end = t;
      if (mw) begin
        if (r_mwcnt == 1) r_mw1++;
        else r_mw2++;
      end
      mw_prev = mw;
      if (probe) begin
        if (pstart < 0) pstart = t;
        r_probe++;
      end
      if (sample) begin
        if (r_soff < 0) r_soff = t - pstart;
        r_slen++;
      end
      drive(plan, t);
      step();
      t++;
      if (seq_start) begin
        done  = 1;
        ended = 1;
      end else if (t > 8000) begin
        done = 1;
      end
    end
    check({tag, "_seq_ended"}, ended, 1);
    check({tag, "_pump_len"}, r_pump, PUMP);
    check({tag, "_mw_pulses"}, r_mwcnt, e_mwcnt);
    check({tag, "_mw1_len"}, r_mw1, e_mw1);
    check({tag, "_gap"}, r_gap, e_gap);
    check({tag, "_mw2_len"}, r_mw2, e_mw2);
    check({tag, "_probe_len"}, r_probe, PROBE);
    check({tag, "_sample_off"}, r_soff, SOFF);
    check({tag, "_sample_len"}, r_slen, SLEN);
    check({tag, "_period"}, t, e_period);
  endtask

  task automatic do_reset(input int n);
    load_defaults = 1'b1;
    repeat (n) step();
    load_defaults = 1'b0;
  endtask

  typedef struct {
    bit pp, pm, fp, fm;
    int e_pie, e_free;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int waited;
    tbl[0] = '{0, 1, 0, 0, 9, 250};
    tbl[1] = '{0, 0, 1, 0, 9, 251};
    tbl[2] = '{1, 1, 0, 0, 9, 251};
    tbl[3] = '{1, 0, 0, 1, 10, 250};
    tbl[4] = '{0, 1, 1, 0, 9, 251};
    tbl[5] = '{0, 0, 1, 1, 9, 251};
    tbl[6] = '{1, 0, 0, 0, 10, 251};
    tbl[7] = '{1, 1, 1, 1, 10, 251};

    // Reset and default Ramsey sequence
    repeat (10) step();
    check("rst_gates", {pump, probe, mw, sample, seq_start}, 0);
    check("rst_pie_len", pie_len, PIE_D);
    check("rst_free_len", free_len, FREE_D);
    load_defaults = 1'b0;
    step();
    check("first_pump", pump, 1);
    check("first_seq_start", seq_start, 1);
    expect_seq("dflt", 0, 2, 10, 250, 10, 2820);

    // Adjust during FREE: current sequence unaffected, next one uses new lengths
    expect_seq("adj_cur", 1, 2, 10, 250, 10, 2820);
    check("adj_pie_len", pie_len, 6);
    check("adj_free_len", free_len, 252);
    expect_seq("adj_next", 0, 2, 6, 252, 6, 2814);

    // Reset during PROBE
    waited = 0;
    while (!probe && waited < 4000) begin
      step();
      waited++;
    end
    check("probe_reached", probe, 1);
    repeat (60) step();
    load_defaults = 1'b1;
    step();
    check("midrst_gates", {pump, probe, mw, sample, seq_start}, 0);
    check("midrst_pie_len", pie_len, PIE_D);
    check("midrst_free_len", free_len, FREE_D);
`ifdef POP_SEQ_COUNT_EN
    check("midrst_seq_count", seq_count, 0);
`endif
    load_defaults = 1'b0;
    step();
    check("midrst_restart", {pump, seq_start}, 2'b11);

    // Mode switch during MW1 takes effect only on the following sequence
    expect_seq("mode_cur", 2, 2, 10, 250, 10, 2820);
    expect_seq("rabi", 0, 1, 10, 0, 0, 2560);
    ramsey_mode = 1'b1;
    expect_seq("rabi_latched", 0, 1, 10, 0, 0, 2560);
`ifdef POP_SEQ_COUNT_EN
    check("seq_count_3", seq_count, 3);
`endif

    // Saturation
    do_reset(2);
    repeat (20) begin
      pm = 1'b1; step();
      pm = 1'b0; step();
    end
    check("pie_sat_min", pie_len, MINL);
    repeat (3) begin
      fp = 1'b1; step();
      fp = 1'b0; step();
    end
    check("free_sat_max", free_len2, MAXL);
    check("free_plus3", free_len, FREE_D + 3);

    // Held button counts once
    do_reset(2);
    fp = 1'b1;
    repeat (100) step();
    fp = 1'b0;
    step();
    check("held_plus", free_len, FREE_D + 1);

    // Button vector table
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      {pp, pm, fp, fm} = {tbl[i].pp, tbl[i].pm, tbl[i].fp, tbl[i].fm};
      step();
      {pp, pm, fp, fm} = 4'b0000;
      step();
      check($sformatf("tbl%0d_pie", i), pie_len, tbl[i].e_pie);
      check($sformatf("tbl%0d_free", i), free_len, tbl[i].e_free);
    end

    // Randomized stimulus, checked by the model every cycle
    do_reset(2);
    for (int c = 0; c < 30000; c++) begin
      pp = ($urandom_range(0, 7) == 0);
      pm = ($urandom_range(0, 7) == 0);
      fp = ($urandom_range(0, 7) == 0);
      fm = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2999) == 0) ramsey_mode = ~ramsey_mode;
      load_defaults = ($urandom_range(0, 9999) == 0);
      step();
    end
    {pp, pm, fp, fm} = 4'b0000;
    load_defaults = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
